// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin arbiter sharing one Parking event port among gate lanes
module parking_gate_arbiter #(
   parameter int NUM_LANES   = 4,
   parameter int OPEN_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LANES-1:0] lane_req,
   input  logic [NUM_LANES-1:0] lane_is_exit,
   input  logic [NUM_LANES-1:0] lane_is_uni,
   input  logic                 uni_is_vacated_space,
   input  logic                 is_vacated_space,
   output logic                 car_entered,
   output logic                 is_uni_car_entered,
   output logic                 car_exited,
   output logic                 is_uni_car_exited,
   output logic [NUM_LANES-1:0] lane_grant,
   output logic [NUM_LANES-1:0] lane_reject,
   output logic [NUM_LANES-1:0] barrier_open,
   output logic                 busy
);
   localparam int IW = $clog2(NUM_LANES);
   typedef enum logic [1:0] {IDLE, ISSUE, OPEN, REJECT} state_e;
   state_e state_q, state_d;
   logic [IW-1:0] rr_q, rr_d, sel_q, sel_d, w, idx, nxt;
   logic [NUM_LANES-1:0] done_q, done_d, elig, sel_mask;
   logic [3:0] cnt_q, cnt_d;
   logic exit_q, exit_d, uni_q, uni_d, found, flag;
   assign elig = lane_req & ~done_q;
   // Descending scan so the lane closest to rr_q wins.
   always_comb begin
      w = '0;
      found = 1'b0;
      idx = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_q) + k) % NUM_LANES);
         if (elig[idx]) begin
            w = idx;
            found = 1'b1;
         end
      end
   end
   assign flag     = lane_is_uni[w] ? uni_is_vacated_space : is_vacated_space;
   assign nxt      = (sel_q == IW'(NUM_LANES - 1)) ? '0 : sel_q + 1'b1;
   assign sel_mask = NUM_LANES'(1) << sel_q;
   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      sel_d = sel_q;
      exit_d = exit_q;
      uni_d = uni_q;
      cnt_d = cnt_q;
      case (state_q)
         IDLE: if (found) begin
            sel_d = w;
            exit_d = lane_is_exit[w];
            uni_d = lane_is_uni[w];
            state_d = (lane_is_exit[w] || flag) ? ISSUE : REJECT;
         end
         ISSUE: begin
            cnt_d = 4'(OPEN_CYCLES - 1);
            rr_d = nxt;
            state_d = (OPEN_CYCLES == 1) ? IDLE : OPEN;
         end
         OPEN: begin
            cnt_d = cnt_q - 1'b1;
            state_d = (cnt_q == 4'd1) ? IDLE : OPEN;
         end
         REJECT: begin
            rr_d = nxt;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign lane_grant         = (state_q == ISSUE) ? sel_mask : '0;
   assign lane_reject        = (state_q == REJECT) ? sel_mask : '0;
   assign barrier_open       = (state_q == ISSUE || state_q == OPEN) ? sel_mask : '0;
   assign car_entered        = (state_q == ISSUE) && !exit_q;
   assign is_uni_car_entered = car_entered && uni_q;
   assign car_exited         = (state_q == ISSUE) && exit_q;
   assign is_uni_car_exited  = car_exited && uni_q;
   assign busy               = state_q != IDLE;
   // A served lane stays masked until it has been seen with req low.
   assign done_d = (done_q | lane_grant | lane_reject) & lane_req;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q <= '0;
         sel_q <= '0;
         done_q <= '0;
         cnt_q <= '0;
         exit_q <= 1'b0;
         uni_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         sel_q <= sel_d;
         done_q <= done_d;
         cnt_q <= cnt_d;
         exit_q <= exit_d;
         uni_q <= uni_d;
      end
   end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed checks of arbitration, reject, hold-off and reset abort
module tb_parking_gate_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   logic [3:0] lane_req = '0, lane_is_exit = '0, lane_is_uni = '0;
   logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
   logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, busy;
   logic [3:0] lane_grant, lane_reject, barrier_open;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   parking_gate_arbiter #(.NUM_LANES(4), .OPEN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .lane_req(lane_req), .lane_is_exit(lane_is_exit),
      .lane_is_uni(lane_is_uni), .uni_is_vacated_space(uni_is_vacated_space),
      .is_vacated_space(is_vacated_space), .car_entered(car_entered),
      .is_uni_car_entered(is_uni_car_entered), .car_exited(car_exited),
      .is_uni_car_exited(is_uni_car_exited), .lane_grant(lane_grant),
      .lane_reject(lane_reject), .barrier_open(barrier_open), .busy(busy)
   );
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      checks++;
      if ({car_entered, car_exited, is_uni_car_entered, is_uni_car_exited, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pulses got %b exp 00000", {car_entered, car_exited, is_uni_car_entered, is_uni_car_exited, busy});
      end
      checks++;
      if ({lane_grant, lane_reject, barrier_open} !== 12'b0) begin
         errors++;
         $display("FAIL reset_lanes got %b exp 0", {lane_grant, lane_reject, barrier_open});
      end
   endtask
   task automatic test_single();
      lane_req = 4'b0001; lane_is_exit = 4'b0000; lane_is_uni = 4'b0001; uni_is_vacated_space = 1'b1;
      @(negedge clk);
      checks++;
      if ({lane_grant, car_entered, is_uni_car_entered, car_exited, barrier_open, busy} !== {4'b0001, 3'b110, 4'b0001, 1'b1}) begin
         errors++;
         $display("FAIL single_issue got g=%b ce=%b ue=%b cx=%b bo=%b busy=%b", lane_grant, car_entered, is_uni_car_entered, car_exited, barrier_open, busy);
      end
      lane_req = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({lane_grant, car_entered, barrier_open, busy} !== {4'b0000, 1'b0, 4'b0001, 1'b1}) begin
            errors++;
            $display("FAIL single_open%0d got g=%b ce=%b bo=%b busy=%b exp bo=0001 busy=1", i, lane_grant, car_entered, barrier_open, busy);
         end
      end
      @(negedge clk);
      checks++;
      if ({barrier_open, busy} !== 5'b0) begin
         errors++;
         $display("FAIL single_close got bo=%b busy=%b exp 0", barrier_open, busy);
      end
   endtask
   task automatic test_round_robin();
      int e, last, ents;
      do_reset();
      e = 0; last = 0; ents = 0;
      lane_req = 4'b1111; lane_is_exit = '0; lane_is_uni = '0; is_vacated_space = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (car_entered) ents++;
         if (lane_grant != 0) begin
            checks++;
            if (lane_grant !== (4'b0001 << e)) begin
               errors++;
               $display("FAIL rr_order%0d got %b exp %b", e, lane_grant, 4'b0001 << e);
            end
            if (e > 0) begin
               checks++;
               if (cyc - last != 4) begin
                  errors++;
                  $display("FAIL rr_spacing%0d got %0d exp 4", e, cyc - last);
               end
            end
            last = cyc;
            e++;
            lane_req = lane_req & ~lane_grant;
         end
      end
      checks++;
      if (e != 4 || ents != 4) begin
         errors++;
         $display("FAIL rr_count got grants=%0d entered=%0d exp 4 4", e, ents);
      end
      lane_req = '0;
   endtask
   task automatic test_reject();
      lane_req = 4'b0100; lane_is_exit = '0; lane_is_uni = 4'b0100;
      uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
      @(negedge clk);
      checks++;
      if ({lane_reject, lane_grant, car_entered, car_exited, barrier_open, busy} !== {4'b0100, 4'b0, 2'b0, 4'b0, 1'b1}) begin
         errors++;
         $display("FAIL reject_pulse got rj=%b g=%b ce=%b cx=%b bo=%b busy=%b", lane_reject, lane_grant, car_entered, car_exited, barrier_open, busy);
      end
      lane_req = '0;
      @(negedge clk);
      checks++;
      if ({lane_reject, barrier_open, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reject_end got rj=%b bo=%b busy=%b exp 0", lane_reject, barrier_open, busy);
      end
      lane_req = 4'b1001; lane_is_uni = '0;
      @(negedge clk);
      checks++;
      if (lane_grant !== 4'b1000) begin
         errors++;
         $display("FAIL reject_rr_ptr got %b exp 1000", lane_grant);
      end
      lane_req = '0;
      repeat (3) @(negedge clk);
   endtask
   task automatic test_exit_no_space();
      lane_req = 4'b0010; lane_is_exit = 4'b0010; lane_is_uni = '0;
      is_vacated_space = 1'b0; uni_is_vacated_space = 1'b0;
      @(negedge clk);
      checks++;
      if ({lane_grant, lane_reject, car_exited, is_uni_car_exited, car_entered} !== {4'b0010, 4'b0, 3'b100}) begin
         errors++;
         $display("FAIL exit_pub got g=%b rj=%b cx=%b ux=%b ce=%b", lane_grant, lane_reject, car_exited, is_uni_car_exited, car_entered);
      end
      lane_req = '0;
      repeat (3) @(negedge clk);
      lane_req = 4'b0100; lane_is_exit = 4'b0100; lane_is_uni = 4'b0100;
      @(negedge clk);
      checks++;
      if ({lane_grant, car_exited, is_uni_car_exited, car_entered, is_uni_car_entered} !== {4'b0100, 4'b1100}) begin
         errors++;
         $display("FAIL exit_uni got g=%b cx=%b ux=%b ce=%b ue=%b", lane_grant, car_exited, is_uni_car_exited, car_entered, is_uni_car_entered);
      end
      lane_req = '0; lane_is_exit = '0; lane_is_uni = '0;
      repeat (3) @(negedge clk);
   endtask
   task automatic test_held();
      int n;
      n = 0;
      lane_req = 4'b0001; is_vacated_space = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (lane_grant[0]) n++;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL held_single got %0d grants exp 1", n);
      end
      lane_req = '0;
      @(negedge clk);
      lane_req = 4'b0001;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (lane_grant[0]) n++;
         if (i == 0) lane_req = '0;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL held_regrant got %0d grants exp 1", n);
      end
   endtask
   task automatic test_mid_reset();
      int n;
      n = 0;
      lane_req = 4'b0010; lane_is_exit = '0; lane_is_uni = '0; is_vacated_space = 1'b1;
      @(negedge clk);
      checks++;
      if (lane_grant !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_grant got %b exp 0010", lane_grant);
      end
      lane_req = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({barrier_open, busy} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_abort got bo=%b busy=%b exp 0", barrier_open, busy);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (lane_grant != 0 || car_entered || busy) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL midrst_quiet got %0d active cycles exp 0", n);
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_reject();
      test_exit_no_space();
      test_held();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Shares the single-event-per-cycle Parking datapath between NUM_LANES physical gate lanes. Each lane can be an entry or an exit.
- Round-robin arbitration picks one lane per transaction. Entries are checked against the Parking space flags, and the block drives exactly one car_entered/car_exited pulse per granted car.
- Each lane's barrier is held open for OPEN_CYCLES cycles after its grant.
- Sits between lane sensors/ticket readers and the Parking module.

Parameters:
- NUM_LANES, 4, number of requesting gate lanes (2..8).
- OPEN_CYCLES, 3, cycles barrier_open stays high per grant, counting the issue cycle (1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- lane_req  input  NUM_LANES  per-lane request; held high until that lane's grant/reject pulse
- lane_is_exit  input  NUM_LANES  1 = exit request, 0 = entry request; valid while lane_req is high
- lane_is_uni  input  NUM_LANES  1 = university car, 0 = public car
- uni_is_vacated_space  input  1  from Parking; university space available
- is_vacated_space  input  1  from Parking; public space available
- car_entered  output  1  one-cycle pulse to Parking
- is_uni_car_entered  output  1  qualifies car_entered
- car_exited  output  1  one-cycle pulse to Parking
- is_uni_car_exited  output  1  qualifies car_exited
- lane_grant  output  NUM_LANES  one-hot, one-cycle grant pulse
- lane_reject  output  NUM_LANES  one-hot, one-cycle reject pulse (entry with no space)
- barrier_open  output  NUM_LANES  one-hot barrier drive
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - All outputs go to 0; state = IDLE; rr_ptr = 0; done_mask = 0; open counter = 0.
  - rst mid-transaction aborts it: barrier closes the next cycle and no pending pulse is issued.
- Eligibility: lane i is eligible when lane_req[i] = 1 and done_mask[i] = 0.
- done_mask[i]:
  - set in the cycle lane_grant[i] or lane_reject[i] pulses;
  - cleared in any cycle where lane_req[i] is sampled 0.
  - Effect: a lane must drop req for at least 1 cycle before it is served again, so a held req never double-counts a car.
- States: IDLE, ISSUE, OPEN, REJECT.
- IDLE:
  - Find the first eligible lane w, scanning rr_ptr, rr_ptr+1, … mod NUM_LANES.
  - No eligible lane: stay in IDLE.
  - Exit request: go to ISSUE.
  - Entry request: sample the space flag (lane_is_uni[w] ? uni_is_vacated_space : is_vacated_space). Flag = 1 → ISSUE; flag = 0 → REJECT.
  - Latch w, lane_is_exit[w] and lane_is_uni[w] at the decision edge. Later changes on those inputs are ignored.
- ISSUE (exactly 1 cycle):
  - Pulse lane_grant[w].
  - Pulse car_entered with is_uni_car_entered = latched uni for an entry, or car_exited with is_uni_car_exited = latched uni for an exit. The unused pair stays 0.
  - barrier_open[w] goes high.
  - Load open counter = OPEN_CYCLES-1.
  - rr_ptr = (w+1) mod NUM_LANES.
  - Next state: OPEN, or IDLE if OPEN_CYCLES = 1.
- OPEN:
  - barrier_open[w] stays high; counter decrements each cycle.
  - At counter = 1 the next state is IDLE, and barrier_open drops on entering IDLE.
  - Total barrier_open high time = OPEN_CYCLES cycles.
- REJECT (1 cycle): pulse lane_reject[w]; rr_ptr = (w+1) mod NUM_LANES; next state IDLE.
- Latency: req sampled in IDLE → grant/reject pulse on the next cycle. Minimum spacing between Parking pulses = OPEN_CYCLES+1 cycles.
- Simultaneous requests: only one is served per transaction; the others wait. The round-robin pointer guarantees each of N continuously eligible lanes is served within N transactions.
- Never assert car_entered and car_exited in the same cycle. At most one bit of lane_grant/lane_reject/barrier_open is set at any time.
- Space flags are sampled only in IDLE; a flag change during OPEN has no effect on the current car.
- A lane dropping req after being selected does not cancel its transaction.

Test Plan:
- Reset, then single request: rst 2 cycles, then lane_req = 0001, is_exit = 0, is_uni = 1, uni flag = 1 → one cycle later lane_grant = 0001, car_entered = 1, is_uni_car_entered = 1 for exactly 1 cycle; barrier_open = 0001 for 3 cycles; busy high for 3 cycles.
- Round-robin: lane_req = 1111, all public entries, is_vacated_space = 1, each lane drops req 1 cycle after its grant → grants in order lanes 0, 1, 2, 3, spaced 4 cycles apart; 4 car_entered pulses total.
- Reject: lane 2 university entry with uni_is_vacated_space = 0 → lane_reject = 0100 for 1 cycle; no car_entered; barrier stays closed; rr_ptr moves to 3.
- Exit with no space: lane 1 exit, is_uni = 0, is_vacated_space = 0 → grant; car_exited = 1, is_uni_car_exited = 0.
- Held request: lane 0 holds req high for 20 cycles → exactly 1 grant; after req low for 1 cycle then high again → second grant.
- Mid-operation reset: rst asserted in the second OPEN cycle → barrier_open = 0 and state IDLE the next cycle; no further grant until a new request arrives.
